inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter A, default affine::A, meaning instruction address width.
REQ-002 SHALL have parameter W_INST, default affine::W_INST, meaning instruction word width.
REQ-003 SHALL have parameter LAST, default 3, meaning the final program address of the sequence.
REQ-004 SHALL have port refresh_clk  input  1  meaning the single clock; all state rises on its positive edge.
REQ-005 SHALL have port rst_i  input  1  meaning the reset: asynchronous assertion, active-high.
REQ-006 SHALL have port start_i  input  1  meaning a start pulse, sampled in IDLE only.
REQ-007 SHALL have port jump_i  input  1  meaning a PC redirect request, sampled in FETCH only.
REQ-008 SHALL have port jump_addr_i  input  A  meaning the redirect target address.
REQ-009 SHALL have port addr_o  output  A  meaning the instruction ROM address, equal to the PC register.
REQ-010 SHALL have port data_i  input  W_INST  meaning the ROM word; combinational from addr_o, same cycle.
REQ-011 SHALL have port inst_o  output  W_INST  meaning the registered instruction presented to decode.
REQ-012 SHALL have port inst_pc_o  output  A  meaning the address inst_o was fetched from.
REQ-013 SHALL have port inst_valid_o  output  1  meaning inst_o/inst_pc_o are valid.
REQ-014 SHALL have port inst_ready_i  input  1  meaning decode accepts the instruction this cycle.
REQ-015 SHALL have port done_o  output  1  meaning the sequence has completed (DONE state).

Function
REQ-016 SHALL implement states IDLE, FETCH, DONE.
REQ-017 SHALL move IDLE->FETCH when start_i=1, loading PC=0.
REQ-018 SHALL, in FETCH, capture data_i into inst_o and PC into inst_pc_o, set inst_valid_o=1, and increment PC modulo 2^A when the output slot is free (inst_valid_o=0, or inst_valid_o=1 with inst_ready_i=1).
REQ-019 SHALL hold inst_o, inst_pc_o, inst_valid_o and PC stable while inst_valid_o=1 and inst_ready_i=0.
REQ-020 SHALL clear inst_valid_o after a handshake when no new capture occurs.
REQ-021 SHALL give first-instruction latency as follows: start_i high in cycle 0, addr_o=0 in cycle 1, inst_valid_o=1 with word 0 in cycle 2. Throughput SHALL be one instruction per cycle while inst_ready_i=1.
REQ-022 SHALL treat jump_i=1 in FETCH as follows: PC<=jump_addr_i; no capture that cycle; inst_valid_o=0 next cycle. A handshake in the same cycle SHALL still count as consumed.
REQ-023 SHALL, on capture of address LAST without FETCH_LOOP_EN, stop capturing and enter DONE; the captured word SHALL remain valid until handshaked.
REQ-024 SHALL set done_o=1 in DONE and ignore start_i and jump_i there; only reset leaves DONE.
REQ-025 SHALL ignore start_i in FETCH and jump_i in IDLE.
REQ-026 SHALL, when a jump and capture of LAST coincide, have the jump take priority (no DONE transition).

Reset
REQ-027 SHALL, on rst_i=1, immediately set state=IDLE, PC=0, addr_o=0, inst_o=0, inst_pc_o=0, inst_valid_o=0, done_o=0, including mid-FETCH; any pending instruction SHALL be discarded.
REQ-028 SHALL resume only on a fresh start_i after rst_i deasserts.

Configuration
REQ-029 SHALL, with macro FETCH_LOOP_EN defined, load PC=0 on capture of address LAST and remain in FETCH (continuous loop, done_o stays 0); without it, behaviour SHALL be per REQ-023.

Verification
REQ-030 SHALL verify the sequence: bench ROM 0:14014EC, 1:3904060, 2:39560C0, 3:0840100, ready=1, start pulse -> inst_o 14014EC, 3904060, 39560C0, 0840100 in cycles 2-5, then done_o=1 from cycle 6.
REQ-031 SHALL verify backpressure: ready=0 in cycles 2-4 -> inst_o=14014EC and inst_pc_o=0 held; addr_o=1 held; word 1 appears the cycle after ready returns.
REQ-032 SHALL verify a jump: jump_i with addr 2 while word 0 is valid -> inst_valid_o=0 next cycle, then inst_pc_o=2 with 39560C0.
REQ-033 SHALL verify reset mid-run: rst_i asserted during word 1 -> all outputs 0 in the same cycle; no fetch until the next start_i.
REQ-034 SHALL verify looping: with FETCH_LOOP_EN and ready=1 -> inst_pc_o sequence 0,1,2,3,0,1 with done_o=0.
REQ-035 SHALL verify ignored inputs: start_i in FETCH and jump_i in DONE -> no change to PC or outputs.

Source files
------------

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch -- sequential instruction fetch unit
//
// Walks a program ROM from address 0 up to LAST. Each fetched word is
// registered together with its address and offered to decode through a
// valid/ready handshake. A redirect (jump) reloads the PC and drops the
// pending slot.
//
// Optional feature (compile-time macro):
//   FETCH_LOOP_EN  - after capturing address LAST, reload PC=0 and keep
//                    fetching forever instead of stopping in DONE.
//
// Ports:
//   refresh_clk   in   clock, all state updates on rising edge
//   rst_i         in   asynchronous active-high reset
//   start_i       in   start pulse (honoured in IDLE only)
//   jump_i        in   redirect request (honoured in FETCH only)
//   jump_addr_i   in   [A]      redirect target
//   addr_o        out  [A]      ROM address (the PC register)
//   data_i        in   [W_INST] ROM word for addr_o, same cycle
//   inst_o        out  [W_INST] registered instruction to decode
//   inst_pc_o     out  [A]      address inst_o came from
//   inst_valid_o  out  inst_o / inst_pc_o valid
//   inst_ready_i  in   decode accepts the instruction this cycle
//   done_o        out  sequence complete
// -----------------------------------------------------------------------------

package affine;
    localparam int A      = 8;
    localparam int W_INST = 32;
endpackage

module inst_fetch #(
    parameter int A      = affine::A,
    parameter int W_INST = affine::W_INST,
    parameter int LAST   = 3
) (
    input  logic              refresh_clk,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              jump_i,
    input  logic [A-1:0]      jump_addr_i,
    output logic [A-1:0]      addr_o,
    input  logic [W_INST-1:0] data_i,
    output logic [W_INST-1:0] inst_o,
    output logic [A-1:0]      inst_pc_o,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic              done_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [A-1:0] LAST_PC = A'(LAST);

    state_t              state_q, state_d;
    logic [A-1:0]        pc_q, pc_d;
    logic [W_INST-1:0]   inst_q, inst_d;
    logic [A-1:0]        inst_pc_q, inst_pc_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;
    logic                slot_free;

    // The output register can take a new word if it is empty or is being
    // handed to decode in this very cycle.
    assign slot_free = !valid_q || inst_ready_i;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        valid_d   = valid_q;
        // done_o is a registered view of the DONE state, so it rises the
        // cycle after the state has moved to DONE.
        done_d    = (state_q == DONE);

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = FETCH;
                    pc_d    = '0;
                end
            end

            FETCH: begin
                if (jump_i) begin
                    // Redirect wins over any capture (including LAST); the
                    // pending word, handshaked or not, is dropped.
                    pc_d    = jump_addr_i;
                    valid_d = 1'b0;
                end else if (slot_free) begin
                    inst_d    = data_i;
                    inst_pc_d = pc_q;
                    valid_d   = 1'b1;
                    if (pc_q == LAST_PC) begin
`ifdef FETCH_LOOP_EN
                        pc_d = '0;
`else
                        // PC parks on LAST; the captured word stays valid
                        // until decode takes it in DONE.
                        state_d = DONE;
`endif
                    end else begin
                        pc_d = pc_q + A'(1);
                    end
                end
            end

            DONE: begin
                if (valid_q && inst_ready_i) begin
                    valid_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge refresh_clk or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            pc_q      <= '0;
            inst_q    <= '0;
            inst_pc_q <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
        end
    end

    assign addr_o       = pc_q;
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;
    assign inst_valid_o = valid_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch -- directed bench for inst_fetch
//
// Drives a 4-word ROM and walks through: plain sequence to DONE (or the
// looping sequence when FETCH_LOOP_EN is defined), backpressure with an
// ignored start, asynchronous reset mid-run, and a jump. Cycle numbers in
// comments count rising edges after the start pulse was applied (cycle 0).
// -----------------------------------------------------------------------------
module tb_inst_fetch;

    localparam int A = affine::A;
    localparam int W = affine::W_INST;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic          jump_i;
    logic [A-1:0]  jump_addr_i;
    logic [A-1:0]  addr_o;
    logic [W-1:0]  data_i;
    logic [W-1:0]  inst_o;
    logic [A-1:0]  inst_pc_o;
    logic          inst_valid_o;
    logic          inst_ready_i;
    logic          done_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    inst_fetch dut (
        .refresh_clk  (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .jump_i       (jump_i),
        .jump_addr_i  (jump_addr_i),
        .addr_o       (addr_o),
        .data_i       (data_i),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .inst_valid_o (inst_valid_o),
        .inst_ready_i (inst_ready_i),
        .done_o       (done_o)
    );

    // Bench ROM; unprogrammed addresses return a recognisable filler.
    always_comb begin
        case (addr_o)
            8'd0:    data_i = 32'h014014EC;
            8'd1:    data_i = 32'h03904060;
            8'd2:    data_i = 32'h039560C0;
            8'd3:    data_i = 32'h00840100;
            default: data_i = 32'hDEADBE00 | 32'(addr_o);
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
            $display("check %-24s ok  value=%h", tag, obs);
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [W-1:0] inst,
                           input logic [A-1:0] pc, input logic [A-1:0] addr, input logic dn);
        chk({tag, ".valid"}, 64'(inst_valid_o), 64'(v));
        chk({tag, ".inst"},  64'(inst_o),       64'(inst));
        chk({tag, ".pc"},    64'(inst_pc_o),    64'(pc));
        chk({tag, ".addr"},  64'(addr_o),       64'(addr));
        chk({tag, ".done"},  64'(done_o),       64'(dn));
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        #1;
        tick();
        rst_i = 1'b0;
        tick();
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; jump_i = 1'b0; jump_addr_i = '0; inst_ready_i = 1'b1;
        #1;
        chk_out("reset", 1'b0, 32'h0, 8'd0, 8'd0, 1'b0);
        tick();
        rst_i = 1'b0;
        tick();
        tick();
        chk_out("idle", 1'b0, 32'h0, 8'd0, 8'd0, 1'b0);

        // ---------------- sequence (or loop) with ready=1 -----------------
        start_i = 1'b1; inst_ready_i = 1'b1;         // cycle 0
        tick(); start_i = 1'b0;                       // cycle 1
        chk("seq.c1.addr",  64'(addr_o), 64'd0);
        chk("seq.c1.valid", 64'(inst_valid_o), 64'd0);
        tick();                                       // cycle 2
        chk_out("seq.c2", 1'b1, 32'h014014EC, 8'd0, 8'd1, 1'b0);
        tick();
        chk_out("seq.c3", 1'b1, 32'h03904060, 8'd1, 8'd2, 1'b0);
        tick();
        chk_out("seq.c4", 1'b1, 32'h039560C0, 8'd2, 8'd3, 1'b0);
        tick();
`ifdef FETCH_LOOP_EN
        chk_out("loop.c5", 1'b1, 32'h00840100, 8'd3, 8'd0, 1'b0);
        tick();
        chk_out("loop.c6", 1'b1, 32'h014014EC, 8'd0, 8'd1, 1'b0);
        tick();
        chk_out("loop.c7", 1'b1, 32'h03904060, 8'd1, 8'd2, 1'b0);
`else
        chk_out("seq.c5", 1'b1, 32'h00840100, 8'd3, 8'd3, 1'b0);
        tick();
        chk_out("seq.c6", 1'b0, 32'h00840100, 8'd3, 8'd3, 1'b1);
        // jump and start in DONE are ignored
        jump_i = 1'b1; jump_addr_i = 8'd2; start_i = 1'b1;
        tick();
        jump_i = 1'b0; start_i = 1'b0;
        tick();
        chk_out("done.ignore", 1'b0, 32'h00840100, 8'd3, 8'd3, 1'b1);
`endif
        do_reset();

        // ---------------- backpressure, start ignored in FETCH ------------
        start_i = 1'b1; inst_ready_i = 1'b1;         // cycle 0
        tick(); start_i = 1'b0;                       // cycle 1
        tick();                                       // cycle 2
        chk_out("bp.c2", 1'b1, 32'h014014EC, 8'd0, 8'd1, 1'b0);
        inst_ready_i = 1'b0;
        tick();                                       // cycle 3
        chk_out("bp.c3", 1'b1, 32'h014014EC, 8'd0, 8'd1, 1'b0);
        start_i = 1'b1;                               // ignored in FETCH
        tick();                                       // cycle 4
        start_i = 1'b0;
        chk_out("bp.c4", 1'b1, 32'h014014EC, 8'd0, 8'd1, 1'b0);
        tick();                                       // cycle 5
        chk_out("bp.c5", 1'b1, 32'h014014EC, 8'd0, 8'd1, 1'b0);
        inst_ready_i = 1'b1;
        tick();                                       // cycle 6
        chk_out("bp.c6", 1'b1, 32'h03904060, 8'd1, 8'd2, 1'b0);

        // ---------------- asynchronous reset while word 1 is valid --------
        #2;
        rst_i = 1'b1;
        #1;
        chk_out("rst.async", 1'b0, 32'h0, 8'd0, 8'd0, 1'b0);
        tick();
        rst_i = 1'b0;
        tick();
        tick();
        tick();
        chk_out("rst.nofetch", 1'b0, 32'h0, 8'd0, 8'd0, 1'b0);

        // ---------------- jump while word 0 is valid ----------------------
        start_i = 1'b1; inst_ready_i = 1'b1;         // cycle 0
        tick(); start_i = 1'b0;                       // cycle 1
        tick();                                       // cycle 2
        chk_out("jmp.c2", 1'b1, 32'h014014EC, 8'd0, 8'd1, 1'b0);
        jump_i = 1'b1; jump_addr_i = 8'd2;
        tick();                                       // cycle 3
        jump_i = 1'b0;
        chk("jmp.c3.valid", 64'(inst_valid_o), 64'd0);
        chk("jmp.c3.addr",  64'(addr_o),       64'd2);
        tick();                                       // cycle 4
        chk_out("jmp.c4", 1'b1, 32'h039560C0, 8'd2, 8'd3, 1'b0);
        // jump coinciding with capture of LAST: jump wins, no DONE
        jump_i = 1'b1; jump_addr_i = 8'd1;
        tick();                                       // cycle 5
        jump_i = 1'b0;
        chk("jmp.last.valid", 64'(inst_valid_o), 64'd0);
        chk("jmp.last.addr",  64'(addr_o),       64'd1);
        tick();                                       // cycle 6
        chk_out("jmp.c6", 1'b1, 32'h03904060, 8'd1, 8'd2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
